// File: rtl/pagerank_pkg.sv
// ---------------------------------------------------------------------------
// pagerank_pkg
// Shared definitions for the PageRank gather accumulator:
//   gather_state_e : gather FSM states (ACCUM, DRAIN, DONE)
//   lane_req_t     : one scatter lane request (valid, id, data) at the widest
//                    supported id/data widths
//   MAX_LANES      : upper bound on the number of parallel scatter lanes
// ---------------------------------------------------------------------------
package pagerank_pkg;

    localparam int MAX_LANES   = 8;
    localparam int LANE_ID_W   = 8;
    localparam int LANE_DATA_W = 64;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } gather_state_e;

    typedef struct packed {
        logic                   valid;
        logic [LANE_ID_W-1:0]   id;
        logic [LANE_DATA_W-1:0] data;
    } lane_req_t;

endpackage

// File: rtl/pagerank_gather_accum_if.sv
// ---------------------------------------------------------------------------
// pagerank_gather_accum_if
// Bundles the scatter-side inputs and the accumulator-side outputs of
// pagerank_gather_accum.
//   master : the scatter engine / consumer (drives lane inputs and control)
//   slave  : the gather accumulator (drives accumulator contents and status)
// ---------------------------------------------------------------------------
interface pagerank_gather_accum_if
    import pagerank_pkg::*;
#(
    parameter int NODES_IN_GRAPH = 32,
    parameter int DATA_WIDTH     = 64,
    parameter int NUM_LANES      = 2,
    parameter int ID_WIDTH       = $clog2(NODES_IN_GRAPH)
);
    logic                  pagerank_enable;
    logic                  nextIteration;
    logic [DATA_WIDTH-1:0] page_rank_scatter [NUM_LANES];
    logic [ID_WIDTH-1:0]   dest_id           [NUM_LANES];
    logic [NUM_LANES-1:0]  pagerank_ready;
    logic                  scatter_operation_complete;
    logic [DATA_WIDTH-1:0] pagerank_pre_damp [NODES_IN_GRAPH];
    logic                  gather_operation_complete;
    logic [31:0]           update_count;
    logic                  drop_flag;
    logic                  sat_flag;

    modport master (
        output pagerank_enable, nextIteration, page_rank_scatter, dest_id,
               pagerank_ready, scatter_operation_complete,
        input  pagerank_pre_damp, gather_operation_complete, update_count,
               drop_flag, sat_flag
    );

    modport slave (
        input  pagerank_enable, nextIteration, page_rank_scatter, dest_id,
               pagerank_ready, scatter_operation_complete,
        output pagerank_pre_damp, gather_operation_complete, update_count,
               drop_flag, sat_flag
    );

endinterface

// File: rtl/pagerank_sat_add.sv
// ---------------------------------------------------------------------------
// pagerank_sat_add
// One accumulator update: acc_i + inc_i, where inc_i is the merged sum of all
// lanes hitting this node in a cycle.
// Optional feature macro: PAGERANK_SAT_EN
//   defined   : result clamps to all-ones on overflow
//   undefined : result wraps modulo 2^DATA_WIDTH, no clamp logic
// Ports:
//   acc_i  current accumulator value
//   inc_i  merged lane contribution (wider than the accumulator)
//   sum_o  value to write back
//   ovf_o  the true sum does not fit in DATA_WIDTH bits
// ---------------------------------------------------------------------------
module pagerank_sat_add #(
    parameter int DATA_WIDTH = 64,
    parameter int SUM_W      = 66
) (
    input  logic [DATA_WIDTH-1:0] acc_i,
    input  logic [SUM_W-1:0]      inc_i,
    output logic [DATA_WIDTH-1:0] sum_o,
    output logic                  ovf_o
);
    localparam int RES_W = SUM_W + 1;

    logic [RES_W-1:0] full_sum;

    assign full_sum = RES_W'(acc_i) + RES_W'(inc_i);
    assign ovf_o    = |full_sum[RES_W-1:DATA_WIDTH];

`ifdef PAGERANK_SAT_EN
    function automatic logic [DATA_WIDTH-1:0] saturate(input logic [RES_W-1:0] v);
        if (|v[RES_W-1:DATA_WIDTH]) begin
            return '1;
        end
        return v[DATA_WIDTH-1:0];
    endfunction

    assign sum_o = saturate(full_sum);
`else
    assign sum_o = full_sum[DATA_WIDTH-1:0];
`endif

endmodule

// File: rtl/pagerank_gather_accum.sv
// ---------------------------------------------------------------------------
// pagerank_gather_accum
// Multi-lane PageRank gather accumulator. Up to NUM_LANES scatter
// contributions per cycle are registered (S1), merged per destination node and
// added into a per-node register file (S2). Gather completion is flagged only
// once every accepted contribution has been committed.
// Optional feature macro: PAGERANK_SAT_EN (saturating accumulators + sat_flag)
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      pagerank_gather_accum_if.slave: lane inputs, control, accumulator
//            contents, gather_operation_complete, update_count, drop_flag,
//            sat_flag
// ---------------------------------------------------------------------------
module pagerank_gather_accum
    import pagerank_pkg::*;
#(
    parameter int NODES_IN_GRAPH = 32,
    parameter int DATA_WIDTH     = 64,
    parameter int NUM_LANES      = 2,
    parameter int ID_WIDTH       = $clog2(NODES_IN_GRAPH)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    pagerank_gather_accum_if.slave  bus
);
    localparam int SUM_W = DATA_WIDTH + $clog2(NUM_LANES) + 1;

    localparam logic [1:0] ST_ACCUM = ACCUM;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam logic [1:0] ST_DONE  = DONE;

    if (NUM_LANES < 1 || NUM_LANES > MAX_LANES) begin : g_bad_lanes
        $error("pagerank_gather_accum: NUM_LANES must be within 1..MAX_LANES");
    end

    logic [1:0]            state_q, state_d;
    logic                  done_q;
    logic [31:0]           count_q;
    logic                  drop_q;
    logic [NUM_LANES-1:0]  s1_vld_q, s1_vld_d;
    logic [ID_WIDTH-1:0]   s1_id_q   [NUM_LANES];
    logic [DATA_WIDTH-1:0] s1_data_q [NUM_LANES];
    logic [DATA_WIDTH-1:0] acc_q     [NODES_IN_GRAPH];

    logic                      capture_en;
    logic [NUM_LANES-1:0]      lane_drop;
    logic [3:0]                accept_cnt;
    logic [32:0]               count_sum;
    logic [SUM_W-1:0]          node_sum  [NODES_IN_GRAPH];
    logic [DATA_WIDTH-1:0]     acc_next  [NODES_IN_GRAPH];
    logic [NODES_IN_GRAPH-1:0] node_hit;
    logic [NODES_IN_GRAPH-1:0] node_ovf;

    // The DRAIN-entry cycle is still ACCUM, so its lane inputs are captured.
    assign capture_en = bus.pagerank_enable && !bus.nextIteration && (state_q == ST_ACCUM);

    always_comb begin
        s1_vld_d   = '0;
        lane_drop  = '0;
        accept_cnt = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (capture_en && bus.pagerank_ready[k]) begin
                if (int'(bus.dest_id[k]) >= NODES_IN_GRAPH) begin
                    lane_drop[k] = 1'b1;
                end else begin
                    s1_vld_d[k] = 1'b1;
                    accept_cnt  = accept_cnt + 4'd1;
                end
            end
        end
    end

    assign count_sum = {1'b0, count_q} + {29'd0, accept_cnt};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: if (bus.scatter_operation_complete && bus.pagerank_enable) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_ACCUM;
        endcase
        if (bus.nextIteration) begin
            state_d = ST_ACCUM;
        end
    end

    // ---- S1: lane capture and bookkeeping ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_ACCUM;
            done_q   <= 1'b0;
            count_q  <= '0;
            drop_q   <= 1'b0;
            s1_vld_q <= '0;
        end else begin
            state_q  <= state_d;
            done_q   <= (state_d == ST_DONE);
            s1_vld_q <= s1_vld_d;
            if (bus.nextIteration) begin
                count_q <= '0;
                drop_q  <= 1'b0;
            end else begin
                count_q <= count_sum[32] ? '1 : count_sum[31:0];
                drop_q  <= drop_q | (|lane_drop);
            end
        end
    end

    always_ff @(posedge clock) begin
        s1_id_q   <= bus.dest_id;
        s1_data_q <= bus.page_rank_scatter;
    end

    // ---- S2: per-node lane merge and accumulator commit ----
    // Colliding lanes are summed first, so each node sees a single write.
    always_comb begin
        for (int n = 0; n < NODES_IN_GRAPH; n++) begin
            node_sum[n] = '0;
            node_hit[n] = 1'b0;
            for (int k = 0; k < NUM_LANES; k++) begin
                if (s1_vld_q[k] && (s1_id_q[k] == ID_WIDTH'(n))) begin
                    node_sum[n] = node_sum[n] + SUM_W'(s1_data_q[k]);
                    node_hit[n] = 1'b1;
                end
            end
        end
    end

    for (genvar n = 0; n < NODES_IN_GRAPH; n++) begin : g_node
        pagerank_sat_add #(
            .DATA_WIDTH (DATA_WIDTH),
            .SUM_W      (SUM_W)
        ) u_add (
            .acc_i (acc_q[n]),
            .inc_i (node_sum[n]),
            .sum_o (acc_next[n]),
            .ovf_o (node_ovf[n])
        );
        assign bus.pagerank_pre_damp[n] = acc_q[n];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int n = 0; n < NODES_IN_GRAPH; n++) acc_q[n] <= '0;
        end else if (bus.nextIteration) begin
            for (int n = 0; n < NODES_IN_GRAPH; n++) acc_q[n] <= '0;
        end else begin
            for (int n = 0; n < NODES_IN_GRAPH; n++) begin
                if (node_hit[n]) acc_q[n] <= acc_next[n];
            end
        end
    end

`ifdef PAGERANK_SAT_EN
    logic sat_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sat_q <= 1'b0;
        end else if (bus.nextIteration) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_q | (|(node_hit & node_ovf));
        end
    end

    assign bus.sat_flag = sat_q;
`else
    logic unused_ovf;
    assign unused_ovf   = ^node_ovf;
    assign bus.sat_flag = 1'b0;
`endif

    assign bus.gather_operation_complete = done_q;
    assign bus.update_count              = count_q;
    assign bus.drop_flag                 = drop_q;

endmodule

// File: tb/tb_pagerank_gather_accum.sv
// ---------------------------------------------------------------------------
// tb_pagerank_gather_accum
// Directed and randomized stimulus against a transaction-level model of the
// gather accumulator: per-node sums, an iteration phase and sticky flags.
// ID_WIDTH is widened to 6 so out-of-range ids such as 40 can be presented.
// ---------------------------------------------------------------------------
module tb_pagerank_gather_accum;
    import pagerank_pkg::*;

    localparam int NODES = 32;
    localparam int DW    = 64;
    localparam int LANES = 2;
    localparam int IDW   = 6;

    bit   clock = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    pagerank_gather_accum_if #(
        .NODES_IN_GRAPH (NODES), .DATA_WIDTH (DW), .NUM_LANES (LANES), .ID_WIDTH (IDW)
    ) bus ();

    pagerank_gather_accum #(
        .NODES_IN_GRAPH (NODES), .DATA_WIDTH (DW), .NUM_LANES (LANES), .ID_WIDTH (IDW)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Reference model state
    logic [DW-1:0]  m_acc  [NODES];
    logic [71:0]    m_pend [NODES];
    bit             m_hit  [NODES];
    logic [31:0]    m_count;
    bit             m_drop, m_sat, m_done;
    int             m_phase;   // 0 accumulating, 1 draining, 2 done

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void model_clear();
        for (int n = 0; n < NODES; n++) begin
            m_acc[n] = '0; m_pend[n] = '0; m_hit[n] = 0;
        end
        m_count = '0; m_drop = 0; m_sat = 0; m_done = 0; m_phase = 0;
    endfunction

    // Evaluated at each rising edge with the inputs the DUT samples there.
    function automatic void model_edge();
        logic [71:0] t;
        if (!reset_n || bus.nextIteration) begin
            model_clear();
            return;
        end
        for (int n = 0; n < NODES; n++) begin
            if (m_hit[n]) begin
                t = {8'd0, m_acc[n]} + m_pend[n];
                if (t > 72'h00_FFFF_FFFF_FFFF_FFFF) begin
`ifdef PAGERANK_SAT_EN
                    m_acc[n] = '1;
                    m_sat    = 1;
`else
                    m_acc[n] = t[63:0];
`endif
                end else begin
                    m_acc[n] = t[63:0];
                end
            end
            m_pend[n] = '0;
            m_hit[n]  = 0;
        end
        if (m_phase == 1) begin
            m_phase = 2;
            m_done  = 1;
        end else if (m_phase == 0 && bus.pagerank_enable) begin
            for (int k = 0; k < LANES; k++) begin
                if (bus.pagerank_ready[k]) begin
                    if (bus.dest_id[k] >= IDW'(NODES)) begin
                        m_drop = 1;
                    end else begin
                        m_pend[bus.dest_id[k]] += {8'd0, bus.page_rank_scatter[k]};
                        m_hit[bus.dest_id[k]]   = 1;
                        if (m_count != 32'hFFFF_FFFF) m_count++;
                    end
                end
            end
            if (bus.scatter_operation_complete) m_phase = 1;
        end
    endfunction

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int n = 0; n < NODES; n++) begin
            chk($sformatf("%s_acc%0d", tag, n), bus.pagerank_pre_damp[n], m_acc[n]);
        end
        chk({tag, "_count"}, 64'(bus.update_count), 64'(m_count));
        chk({tag, "_drop"},  64'(bus.drop_flag), 64'(m_drop));
        chk({tag, "_sat"},   64'(bus.sat_flag), 64'(m_sat));
        chk({tag, "_done"},  64'(bus.gather_operation_complete), 64'(m_done));
    endtask

    task automatic idle_inputs();
        bus.pagerank_enable            = 1'b1;
        bus.nextIteration              = 1'b0;
        bus.scatter_operation_complete = 1'b0;
        bus.pagerank_ready             = '0;
        for (int k = 0; k < LANES; k++) begin
            bus.dest_id[k]           = '0;
            bus.page_rank_scatter[k] = '0;
        end
    endtask

    task automatic set_lane(input int k, input int id, input logic [63:0] val);
        bus.pagerank_ready[k]    = 1'b1;
        bus.dest_id[k]           = IDW'(id);
        bus.page_rank_scatter[k] = val;
    endtask

    task automatic random_lanes(input int max_id);
        lane_req_t r;
        bus.pagerank_enable = ($urandom_range(0, 9) != 0);
        for (int k = 0; k < LANES; k++) begin
            r.valid = $urandom_range(0, 3) != 0;
            r.id    = LANE_ID_W'($urandom_range(0, max_id));
            r.data  = {$urandom, $urandom};
            bus.pagerank_ready[k]    = r.valid;
            bus.dest_id[k]           = r.id[IDW-1:0];
            bus.page_rank_scatter[k] = r.data;
        end
    endtask

    initial begin
        model_clear();
        idle_inputs();

        // Reset state
        reset_n = 1'b0;
        tick(); tick();
        check_all("reset");
        reset_n = 1'b1;
        tick();

        // Single lane: visible one edge after capture, count one edge after sample
        set_lane(0, 3, 64'd5);
        tick();
        idle_inputs();
        chk("single_count_n", 64'(bus.update_count), 64'd1);
        chk("single_latency", bus.pagerank_pre_damp[3], 64'd0);
        tick();
        chk("single_acc3", bus.pagerank_pre_damp[3], 64'd5);
        check_all("single");

        // Collision on node 7
        set_lane(0, 7, 64'd10);
        set_lane(1, 7, 64'd20);
        tick();
        idle_inputs();
        tick();
        chk("collide_acc7", bus.pagerank_pre_damp[7], 64'd30);
        chk("collide_count", 64'(bus.update_count), 64'd3);
        check_all("collide");

        // Out-of-range destination
        set_lane(0, 40, 64'd99);
        tick();
        idle_inputs();
        chk("drop_flag_n1", 64'(bus.drop_flag), 64'd1);
        tick();
        chk("drop_count", 64'(bus.update_count), 64'd3);
        check_all("drop");

        // Overflow on node 0
        set_lane(0, 0, 64'hFFFF_FFFF_FFFF_FFF0);
        tick();
        idle_inputs();
        tick();
        set_lane(0, 0, 64'h20);
        tick();
        idle_inputs();
        tick();
`ifdef PAGERANK_SAT_EN
        chk("ovf_acc0", bus.pagerank_pre_damp[0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ovf_sat",  64'(bus.sat_flag), 64'd1);
`else
        chk("ovf_acc0", bus.pagerank_pre_damp[0], 64'h10);
        chk("ovf_sat",  64'(bus.sat_flag), 64'd0);
`endif
        check_all("ovf");

        // Randomized accumulation, including collisions and drops
        for (int i = 0; i < 200; i++) begin
            random_lanes(39);
            tick();
            if (i % 25 == 24) check_all($sformatf("rand%0d", i));
        end
        idle_inputs();
        tick(); tick();
        check_all("rand_end");

        // Completion: ids 1 and 2 together with scatter_operation_complete
        set_lane(0, 1, 64'd111);
        set_lane(1, 2, 64'd222);
        bus.scatter_operation_complete = 1'b1;
        tick();
        chk("cpl_done_early", 64'(bus.gather_operation_complete), 64'd0);
        idle_inputs();
        set_lane(0, 5, 64'd9);   // pulse during drain, must be ignored
        tick();
        chk("cpl_done", 64'(bus.gather_operation_complete), 64'd1);
        check_all("cpl");
        for (int i = 0; i < 4; i++) begin
            random_lanes(31);
            tick();
        end
        check_all("done_hold");

        // nextIteration in DONE with ready pulses present
        set_lane(0, 4, 64'd77);
        set_lane(1, 6, 64'd88);
        bus.nextIteration = 1'b1;
        tick();
        idle_inputs();
        chk("next_count", 64'(bus.update_count), 64'd0);
        chk("next_done", 64'(bus.gather_operation_complete), 64'd0);
        check_all("next");
        set_lane(0, 4, 64'd7);
        tick();
        idle_inputs();
        tick();
        chk("next_accum_acc4", bus.pagerank_pre_damp[4], 64'd7);
        check_all("next_accum");

        // Asynchronous reset with an update in flight
        set_lane(1, 9, 64'd1234);
        tick();
        idle_inputs();
        reset_n = 1'b0;
        #1;
        model_clear();
        chk("areset_acc4", bus.pagerank_pre_damp[4], 64'd0);
        chk("areset_count", 64'(bus.update_count), 64'd0);
        tick();
        check_all("areset");
        reset_n = 1'b1;
        tick(); tick();
        chk("areset_lost_acc9", bus.pagerank_pre_damp[9], 64'd0);
        check_all("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
